i2c_bus_monitor: RTL and testbench

//  Consumes the released system reset and raw SCL/SDA pins; first logic stage of the I2C controller.
//  Per line: 2-flop synchroniser plus digital glitch filter. Produces filtered levels, SCL edge strobes,

---
 rtl/i2c_bus_monitor.sv | 175 +++++++++++++++++
 tb/tb_i2c_bus_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C line synchroniser, glitch filter and START/STOP/busy detector
// Optional feature macro: I2C_BUS_TIMEOUT_EN (SCL-stuck-low bus timeout).
module i2c_bus_monitor #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_filt,
   output logic sda_filt,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic rep_start,
   output logic stop_det,
   output logic bus_busy,
   output logic bus_timeout
);

   localparam int            CW      = $clog2(FILTER_LEN) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state_q, state_d;

   logic scl_sync1, scl_sync2, sda_sync1, sda_sync2;
   logic [CW-1:0] scl_cnt, sda_cnt;
   logic scl_prev, sda_prev;
   logic [1:0] fill;
   logic armed;
   logic lines_match;

   logic start_c, rep_c, stop_c, rise_c, fall_c, timeout_c;

   // Two-flop synchronisers, idle-high so reset looks like a released bus
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync1 <= 1'b1;
         scl_sync2 <= 1'b1;
         sda_sync1 <= 1'b1;
         sda_sync2 <= 1'b1;
      end else begin
         scl_sync1 <= scl_i;
         scl_sync2 <= scl_sync1;
         sda_sync1 <= sda_i;
         sda_sync2 <= sda_sync1;
      end
   end

   // SCL glitch filter: a new level must persist FILTER_LEN cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_filt <= 1'b1;
         scl_cnt  <= '0;
      end else if (scl_sync2 == scl_filt) begin
         scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
         scl_filt <= scl_sync2;
         scl_cnt  <= '0;
      end else begin
         scl_cnt <= scl_cnt + CW'(1);
      end
   end

   // SDA glitch filter, identical to SCL
   always_ff @(posedge clk) begin
      if (rst) begin
         sda_filt <= 1'b1;
         sda_cnt  <= '0;
      end else if (sda_sync2 == sda_filt) begin
         sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
         sda_filt <= sda_sync2;
         sda_cnt  <= '0;
      end else begin
         sda_cnt <= sda_cnt + CW'(1);
      end
   end

   assign lines_match = (scl_sync2 == scl_filt) && (sda_sync2 == sda_filt);

   // Delayed copies of the filtered lines for edge detection, plus arming.
   // fill waits until sync2 holds real pin samples; arming then requires the
   // filters to agree with the pins, so a bus held low at reset release is
   // absorbed silently instead of looking like a START.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
         fill     <= 2'b00;
         armed    <= 1'b0;
      end else begin
         scl_prev <= scl_filt;
         sda_prev <= sda_filt;
         fill     <= {fill[0], 1'b1};
         if (fill[1] && lines_match)
            armed <= 1'b1;
      end
   end

`ifdef I2C_BUS_TIMEOUT_EN
   localparam logic [15:0] TO_MAX = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] to_cnt;

   // Counts SCL-low cycles while a transaction is open
   always_ff @(posedge clk) begin
      if (rst || state_q == IDLE || scl_filt || timeout_c)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 16'd1;
   end

   // Registered timeout pulse
   always_ff @(posedge clk) begin
      if (rst)
         bus_timeout <= 1'b0;
      else
         bus_timeout <= timeout_c;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign bus_timeout = 1'b0;
`endif

   // Condition decode and bus state next-state logic
   always_comb begin
      state_d   = state_q;
      start_c   = armed & scl_prev & scl_filt & sda_prev & ~sda_filt;
      stop_c    = armed & scl_prev & scl_filt & ~sda_prev & sda_filt;
      rise_c    = armed & ~scl_prev & scl_filt;
      fall_c    = armed & scl_prev & ~scl_filt;
      rep_c     = start_c & (state_q == BUSY);
      timeout_c = 1'b0;
`ifdef I2C_BUS_TIMEOUT_EN
      // A STOP in the same cycle wins over the timeout
      timeout_c = armed & (state_q == BUSY) & ~scl_filt & (to_cnt == TO_MAX) & ~stop_c;
`endif
      case (state_q)
         IDLE: if (start_c) state_d = BUSY;
         BUSY: if (stop_c || timeout_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus state register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Registered one-cycle event pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         rep_start <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_rise  <= rise_c;
         scl_fall  <= fall_c;
         start_det <= start_c;
         rep_start <= rep_c;
         stop_det  <= stop_c;
      end
   end

   assign bus_busy = (state_q == BUSY);

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - directed table-driven bench for i2c_bus_monitor
module tb_i2c_bus_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_i = 1'b1;
   logic sda_i = 1'b1;
   logic scl_filt, sda_filt, scl_rise, scl_fall;
   logic start_det, rep_start, stop_det, bus_busy, bus_timeout;

   int checks = 0;
   int errors = 0;

   int n_start = 0, n_rep = 0, n_stop = 0, n_rise = 0, n_fall = 0, n_to = 0, n_sda_low = 0;

   i2c_bus_monitor #(.FILTER_LEN(4), .TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
      .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .rep_start(rep_start), .stop_det(stop_det),
      .bus_busy(bus_busy), .bus_timeout(bus_timeout)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the falling edge
   always @(negedge clk) begin
      if (start_det)   n_start++;
      if (rep_start)   n_rep++;
      if (stop_det)    n_stop++;
      if (scl_rise)    n_rise++;
      if (scl_fall)    n_fall++;
      if (bus_timeout) n_to++;
      if (!sda_filt)   n_sda_low++;
   end

   typedef struct {
      logic scl;
      logic sda;
      logic e_scl;
      logic e_sda;
      logic e_busy;
      int   e_start;
      int   e_rep;
      int   e_stop;
      int   e_rise;
      int   e_fall;
   } vec_t;

   vec_t vecs[13];

   int s_start, s_rep, s_stop, s_rise, s_fall, s_to, s_low;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      s_start = n_start; s_rep = n_rep; s_stop = n_stop;
      s_rise = n_rise; s_fall = n_fall; s_to = n_to; s_low = n_sda_low;
   endtask

   initial begin
      //            scl  sda  fscl fsda busy st rp sp ri fa
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 1, 0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 0, 0, 0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1, 0};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1, 0};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 0, 0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0, 0};

      // Reset state
      rst = 1'b1;
      tick(3);
      chk("reset scl_filt", int'(scl_filt), 1);
      chk("reset sda_filt", int'(sda_filt), 1);
      chk("reset pulses", int'({scl_rise, scl_fall, start_det, rep_start, stop_det, bus_timeout}), 0);
      chk("reset bus_busy", int'(bus_busy), 0);
      chk("reset armed", int'(dut.armed), 0);
      rst = 1'b0;
      tick(3);
      chk("armed after release", int'(dut.armed), 1);
      tick(5);

      // START latency: SDA falls before edge N
      sda_i = 1'b0;
      tick(5);
      chk("lat sda_filt N+4", int'(sda_filt), 1);
      tick(1);
      chk("lat sda_filt N+5", int'(sda_filt), 0);
      chk("lat start_det N+5", int'(start_det), 0);
      chk("lat busy N+5", int'(bus_busy), 0);
      tick(1);
      chk("lat start_det N+6", int'(start_det), 1);
      chk("lat busy N+6", int'(bus_busy), 1);
      tick(1);
      chk("lat start_det N+7", int'(start_det), 0);
      chk("lat busy N+7", int'(bus_busy), 1);
      snap();
      sda_i = 1'b1;
      tick(12);
      chk("lat stop count", n_stop - s_stop, 1);
      chk("lat busy after stop", int'(bus_busy), 0);

      // 3-cycle SDA glitch is rejected
      snap();
      sda_i = 1'b0;
      tick(3);
      sda_i = 1'b1;
      tick(12);
      chk("glitch3 sda low cycles", n_sda_low - s_low, 0);
      chk("glitch3 start", n_start - s_start, 0);
      chk("glitch3 busy", int'(bus_busy), 0);

      // 4-cycle SDA pulse just passes the filter: START then STOP
      snap();
      sda_i = 1'b0;
      tick(4);
      sda_i = 1'b1;
      tick(14);
      chk("glitch4 start", n_start - s_start, 1);
      chk("glitch4 stop", n_stop - s_stop, 1);
      chk("glitch4 busy", int'(bus_busy), 0);

      // Table of held line states
      for (int i = 0; i < 13; i++) begin
         snap();
         scl_i = vecs[i].scl;
         sda_i = vecs[i].sda;
         tick(12);
         chk($sformatf("vec%0d scl_filt", i), int'(scl_filt), int'(vecs[i].e_scl));
         chk($sformatf("vec%0d sda_filt", i), int'(sda_filt), int'(vecs[i].e_sda));
         chk($sformatf("vec%0d bus_busy", i), int'(bus_busy), int'(vecs[i].e_busy));
         chk($sformatf("vec%0d start", i), n_start - s_start, vecs[i].e_start);
         chk($sformatf("vec%0d rep", i), n_rep - s_rep, vecs[i].e_rep);
         chk($sformatf("vec%0d stop", i), n_stop - s_stop, vecs[i].e_stop);
         chk($sformatf("vec%0d rise", i), n_rise - s_rise, vecs[i].e_rise);
         chk($sformatf("vec%0d fall", i), n_fall - s_fall, vecs[i].e_fall);
      end

      // START, 8 SCL pulses, repeated START, STOP
      snap();
      sda_i = 1'b0;
      tick(12);
      for (int k = 0; k < 8; k++) begin
         scl_i = 1'b0; tick(10);
         scl_i = 1'b1; tick(10);
      end
      scl_i = 1'b0; tick(5);
      sda_i = 1'b1; tick(5);
      scl_i = 1'b1; tick(12);
      sda_i = 1'b0; tick(12);
      scl_i = 1'b0; tick(10);
      scl_i = 1'b1; tick(12);
      sda_i = 1'b1; tick(12);
      chk("xfer rise", n_rise - s_rise, 10);
      chk("xfer start", n_start - s_start, 2);
      chk("xfer rep", n_rep - s_rep, 1);
      chk("xfer stop", n_stop - s_stop, 1);
      chk("xfer busy", int'(bus_busy), 0);

      // SCL held low while busy
      snap();
      sda_i = 1'b0;
      tick(12);
      scl_i = 1'b0;
      tick(150);
`ifdef I2C_BUS_TIMEOUT_EN
      chk("timeout pulses", n_to - s_to, 1);
      chk("timeout busy", int'(bus_busy), 0);
`else
      chk("no-timeout pulses", n_to - s_to, 0);
      chk("no-timeout busy", int'(bus_busy), 1);
`endif
      scl_i = 1'b1;
      tick(12);
      sda_i = 1'b1;
      tick(12);
      chk("post-timeout stop", n_stop - s_stop, 1);
      chk("post-timeout busy", int'(bus_busy), 0);

      // Reset mid-transaction with SDA=0, SCL=1 held
      sda_i = 1'b0;
      tick(12);
      chk("mid busy before rst", int'(bus_busy), 1);
      snap();
      rst = 1'b1;
      tick(2);
      chk("mid rst busy", int'(bus_busy), 0);
      chk("mid rst sda_filt", int'(sda_filt), 1);
      rst = 1'b0;
      tick(20);
      chk("mid sda_filt", int'(sda_filt), 0);
      chk("mid busy", int'(bus_busy), 0);
      chk("mid start", n_start - s_start, 0);
      chk("mid stop", n_stop - s_stop, 0);
      snap();
      sda_i = 1'b1;
      tick(12);
      chk("idle stop count", n_stop - s_stop, 1);
      chk("idle stop busy", int'(bus_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
